// File: rtl/i_mem_fetch_sched.sv
// Round-robin barrel fetch scheduler for instruction memory port A.
// Keeps one PC per thread and allows at most one fetch in flight per thread.
module i_mem_fetch_sched #(
  parameter int          NUM_THREADS      = 4,
  parameter logic [31:0] RESET_PC_BASE    = 32'h0,
  parameter logic [31:0] THREAD_PC_STRIDE = 32'h400,
  localparam int         TID_W            = $clog2(NUM_THREADS)
) (
  input  logic                   QClk,
  input  logic                   RstQnnnH,
  input  logic [NUM_THREADS-1:0] ThreadEnableQ100H,
  input  logic                   StallQ100H,
  output logic [31:0]            PcQ100H,
  output logic                   RdEnableQ100H,
  output logic [TID_W-1:0]       ThreadIdQ100H,
  output logic                   ValidQ101H,
  output logic [TID_W-1:0]       ThreadIdQ101H,
  input  logic                   NextPcValidQ102H,
  input  logic [TID_W-1:0]       NextPcThreadQ102H,
  input  logic [31:0]            NextPcQ102H
);

  logic [31:0]            pcQ [NUM_THREADS];
  logic [NUM_THREADS-1:0] busyQ;
  logic [TID_W-1:0]       lastTid;

  logic [NUM_THREADS-1:0] eligible;
  logic [TID_W-1:0]       selTid;
  logic [TID_W-1:0]       cand;
  logic                   anyEligible;
  logic                   issue;

  assign eligible = ThreadEnableQ100H & ~busyQ;

  // Search starts one past the last winner; offset NUM_THREADS wraps back to lastTid.
  always_comb begin
    selTid      = '0;
    anyEligible = 1'b0;
    cand        = '0;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      cand = lastTid + TID_W'(i);
      if (!anyEligible && eligible[cand]) begin
        selTid      = cand;
        anyEligible = 1'b1;
      end
    end
  end

  assign issue         = anyEligible & ~StallQ100H & ~RstQnnnH;
  assign RdEnableQ100H = issue;
  assign PcQ100H       = issue ? pcQ[selTid] : 32'h0;
  assign ThreadIdQ100H = issue ? selTid : '0;

  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        pcQ[t] <= RESET_PC_BASE + THREAD_PC_STRIDE * 32'(t);
      end
      busyQ         <= '0;
      lastTid       <= TID_W'(NUM_THREADS - 1);
      ValidQ101H    <= 1'b0;
      ThreadIdQ101H <= '0;
    end else begin
      // A returning thread is busy, so it can never be the thread issuing this cycle.
      if (NextPcValidQ102H && busyQ[NextPcThreadQ102H]) begin
        pcQ[NextPcThreadQ102H]   <= NextPcQ102H & 32'hFFFF_FFFC;
        busyQ[NextPcThreadQ102H] <= 1'b0;
      end
      if (issue) begin
        busyQ[selTid] <= 1'b1;
        lastTid       <= selTid;
        ThreadIdQ101H <= selTid;
      end
      ValidQ101H <= issue;
    end
  end

endmodule

// File: tb/tb_i_mem_fetch_sched.sv
// Directed bench for i_mem_fetch_sched; the bench plays the pipeline and
// returns PC+4 (or a patched target) a fixed number of cycles after each issue.
module tb_i_mem_fetch_sched;

  localparam int TID_W = 2;

  logic              QClk;
  logic              RstQnnnH;
  logic [3:0]        ThreadEnableQ100H;
  logic              StallQ100H;
  logic [31:0]       PcQ100H;
  logic              RdEnableQ100H;
  logic [TID_W-1:0]  ThreadIdQ100H;
  logic              ValidQ101H;
  logic [TID_W-1:0]  ThreadIdQ101H;
  logic              NextPcValidQ102H;
  logic [TID_W-1:0]  NextPcThreadQ102H;
  logic [31:0]       NextPcQ102H;

  i_mem_fetch_sched dut (
    .QClk              (QClk),
    .RstQnnnH          (RstQnnnH),
    .ThreadEnableQ100H (ThreadEnableQ100H),
    .StallQ100H        (StallQ100H),
    .PcQ100H           (PcQ100H),
    .RdEnableQ100H     (RdEnableQ100H),
    .ThreadIdQ100H     (ThreadIdQ100H),
    .ValidQ101H        (ValidQ101H),
    .ThreadIdQ101H     (ThreadIdQ101H),
    .NextPcValidQ102H  (NextPcValidQ102H),
    .NextPcThreadQ102H (NextPcThreadQ102H),
    .NextPcQ102H       (NextPcQ102H)
  );

  initial QClk = 1'b0;
  always #5 QClk = ~QClk;

  typedef struct {
    int          tid;
    logic [31:0] pc;
    int          due;
  } ret_t;

  ret_t        retQ[$];
  int          cycle;
  int          retLat;
  logic        autoRet;
  int          patchTid;
  logic [31:0] patchPc;
  int          checks;
  int          errors;

  // Record this cycle's issue, advance one clock, then drive any return due now.
  task automatic tick();
    ret_t r;
    int   hit;
    #1;
    if (autoRet && !RstQnnnH && RdEnableQ100H) begin
      r.tid = int'(ThreadIdQ100H);
      r.pc  = PcQ100H + 32'd4;
      if (r.tid == patchTid) begin
        r.pc     = patchPc;
        patchTid = -1;
      end
      r.due = cycle + retLat;
      retQ.push_back(r);
    end
    @(posedge QClk);
    #1;
    cycle++;
    NextPcValidQ102H  = 1'b0;
    NextPcThreadQ102H = '0;
    NextPcQ102H       = '0;
    hit = -1;
    for (int i = 0; i < retQ.size(); i++) begin
      if (hit < 0 && retQ[i].due == cycle) hit = i;
    end
    if (hit >= 0) begin
      NextPcValidQ102H  = 1'b1;
      NextPcThreadQ102H = TID_W'(retQ[hit].tid);
      NextPcQ102H       = retQ[hit].pc;
      retQ.delete(hit);
    end
    #1;
  endtask

  task automatic doReset(input logic [3:0] mask, input int lat);
    retQ.delete();
    autoRet           = 1'b1;
    retLat            = lat;
    patchTid          = -1;
    StallQ100H        = 1'b0;
    ThreadEnableQ100H = mask;
    RstQnnnH          = 1'b1;
    tick();
    tick();
    RstQnnnH = 1'b0;
    cycle    = 0;
    #1;
  endtask

  task automatic test_reset();
    retQ.delete();
    autoRet           = 1'b0;
    StallQ100H        = 1'b0;
    ThreadEnableQ100H = 4'hF;
    RstQnnnH          = 1'b1;
    tick();
    tick();
    checks++;
    if (RdEnableQ100H !== 1'b0) begin
      errors++; $display("FAIL reset_rden got=%b exp=0", RdEnableQ100H);
    end
    checks++;
    if (ValidQ101H !== 1'b0 || ThreadIdQ101H !== 2'd0) begin
      errors++; $display("FAIL reset_q101 got valid=%b tid=%0d exp valid=0 tid=0", ValidQ101H, ThreadIdQ101H);
    end
    RstQnnnH = 1'b0;
    #1;
    checks++;
    if (RdEnableQ100H !== 1'b1 || ThreadIdQ100H !== 2'd0 || PcQ100H !== 32'h0) begin
      errors++; $display("FAIL reset_first_issue got rden=%b tid=%0d pc=%h exp rden=1 tid=0 pc=0", RdEnableQ100H, ThreadIdQ100H, PcQ100H);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] base [4];
    logic [31:0] expPc;
    base[0] = 32'h000; base[1] = 32'h400; base[2] = 32'h800; base[3] = 32'hC00;
    doReset(4'hF, 2);
    for (int k = 0; k < 8; k++) begin
      expPc = base[k % 4] + 32'(4 * (k / 4));
      checks++;
      if (RdEnableQ100H !== 1'b1 || ThreadIdQ100H !== TID_W'(k % 4) || PcQ100H !== expPc) begin
        errors++; $display("FAIL rr_issue c%0d got rden=%b tid=%0d pc=%h exp rden=1 tid=%0d pc=%h", k, RdEnableQ100H, ThreadIdQ100H, PcQ100H, k % 4, expPc);
      end
      checks++;
      if (k == 0) begin
        if (ValidQ101H !== 1'b0) begin
          errors++; $display("FAIL rr_valid c%0d got=%b exp=0", k, ValidQ101H);
        end
      end else if (ValidQ101H !== 1'b1 || ThreadIdQ101H !== TID_W'((k - 1) % 4)) begin
        errors++; $display("FAIL rr_valid c%0d got valid=%b tid=%0d exp valid=1 tid=%0d", k, ValidQ101H, ThreadIdQ101H, (k - 1) % 4);
      end
      tick();
    end
  endtask

  // Returns one cycle after issue so the two-thread pair can alternate back to back.
  task automatic test_two_threads();
    logic [31:0] expPc;
    doReset(4'b0101, 1);
    for (int k = 0; k < 6; k++) begin
      expPc = (k % 2 == 0 ? 32'h0 : 32'h800) + 32'(4 * (k / 2));
      checks++;
      if (RdEnableQ100H !== 1'b1 || ThreadIdQ100H !== TID_W'((k % 2) * 2) || PcQ100H !== expPc) begin
        errors++; $display("FAIL two_thr c%0d got rden=%b tid=%0d pc=%h exp rden=1 tid=%0d pc=%h", k, RdEnableQ100H, ThreadIdQ100H, PcQ100H, (k % 2) * 2, expPc);
      end
      tick();
    end
  endtask

  task automatic test_single_thread();
    logic        expRd;
    logic [31:0] expPc;
    doReset(4'b0001, 2);
    for (int k = 0; k < 8; k++) begin
      expRd = (k % 3 == 0);
      expPc = expRd ? 32'(4 * (k / 3)) : 32'h0;
      checks++;
      if (RdEnableQ100H !== expRd || PcQ100H !== expPc || ThreadIdQ100H !== 2'd0) begin
        errors++; $display("FAIL single c%0d got rden=%b pc=%h tid=%0d exp rden=%b pc=%h tid=0", k, RdEnableQ100H, PcQ100H, ThreadIdQ100H, expRd, expPc);
      end
      checks++;
      if (ValidQ101H !== (k % 3 == 1)) begin
        errors++; $display("FAIL single_valid c%0d got=%b exp=%b", k, ValidQ101H, (k % 3 == 1));
      end
      tick();
    end
  endtask

  task automatic test_stall();
    doReset(4'hF, 2);
    tick();
    checks++;
    if (RdEnableQ100H !== 1'b1 || ThreadIdQ100H !== 2'd1) begin
      errors++; $display("FAIL stall_pre got rden=%b tid=%0d exp rden=1 tid=1", RdEnableQ100H, ThreadIdQ100H);
    end
    tick();
    StallQ100H = 1'b1;
    #1;
    for (int k = 2; k < 5; k++) begin
      checks++;
      if (RdEnableQ100H !== 1'b0 || PcQ100H !== 32'h0) begin
        errors++; $display("FAIL stall_rden c%0d got rden=%b pc=%h exp rden=0 pc=0", k, RdEnableQ100H, PcQ100H);
      end
      checks++;
      if (ValidQ101H !== (k == 2) || (k == 2 && ThreadIdQ101H !== 2'd1)) begin
        errors++; $display("FAIL stall_valid c%0d got valid=%b tid=%0d exp valid=%b", k, ValidQ101H, ThreadIdQ101H, (k == 2));
      end
      tick();
    end
    StallQ100H = 1'b0;
    #1;
    checks++;
    if (RdEnableQ100H !== 1'b1 || ThreadIdQ100H !== 2'd2 || PcQ100H !== 32'h800) begin
      errors++; $display("FAIL stall_resume got rden=%b tid=%0d pc=%h exp rden=1 tid=2 pc=00000800", RdEnableQ100H, ThreadIdQ100H, PcQ100H);
    end
  endtask

  task automatic test_return_pc();
    doReset(4'hF, 2);
    patchTid = 1;
    patchPc  = 32'h123;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (ThreadIdQ100H !== 2'd0 || PcQ100H !== 32'h4) begin
      errors++; $display("FAIL ret_t0 got tid=%0d pc=%h exp tid=0 pc=00000004", ThreadIdQ100H, PcQ100H);
    end
    tick();
    checks++;
    if (RdEnableQ100H !== 1'b1 || ThreadIdQ100H !== 2'd1 || PcQ100H !== 32'h120) begin
      errors++; $display("FAIL ret_align got rden=%b tid=%0d pc=%h exp rden=1 tid=1 pc=00000120", RdEnableQ100H, ThreadIdQ100H, PcQ100H);
    end
  endtask

  task automatic test_reset_busy();
    doReset(4'hF, 2);
    autoRet = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (RdEnableQ100H !== 1'b1 || ThreadIdQ100H !== 2'd3) begin
      errors++; $display("FAIL rbusy_pre got rden=%b tid=%0d exp rden=1 tid=3", RdEnableQ100H, ThreadIdQ100H);
    end
    RstQnnnH = 1'b1;
    #1;
    checks++;
    if (RdEnableQ100H !== 1'b0) begin
      errors++; $display("FAIL rbusy_gate got rden=%b exp=0", RdEnableQ100H);
    end
    tick();
    RstQnnnH = 1'b0;
    #1;
    checks++;
    if (RdEnableQ100H !== 1'b1 || ThreadIdQ100H !== 2'd0 || PcQ100H !== 32'h0 || ValidQ101H !== 1'b0) begin
      errors++; $display("FAIL rbusy_first got rden=%b tid=%0d pc=%h valid=%b exp rden=1 tid=0 pc=0 valid=0", RdEnableQ100H, ThreadIdQ100H, PcQ100H, ValidQ101H);
    end
    tick();
    checks++;
    if (RdEnableQ100H !== 1'b1 || ThreadIdQ100H !== 2'd1 || PcQ100H !== 32'h400) begin
      errors++; $display("FAIL rbusy_second got rden=%b tid=%0d pc=%h exp rden=1 tid=1 pc=00000400", RdEnableQ100H, ThreadIdQ100H, PcQ100H);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks            = 0;
    errors            = 0;
    cycle             = 0;
    retLat            = 2;
    autoRet           = 1'b0;
    patchTid          = -1;
    patchPc           = '0;
    RstQnnnH          = 1'b1;
    ThreadEnableQ100H = '0;
    StallQ100H        = 1'b0;
    NextPcValidQ102H  = 1'b0;
    NextPcThreadQ102H = '0;
    NextPcQ102H       = '0;
    test_reset();
    test_round_robin();
    test_two_threads();
    test_single_thread();
    test_stall();
    test_return_pc();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
